// File: rtl/div8u4_restoring_seq.sv
// Sequential 8-bit by 4-bit unsigned restoring divider, one quotient bit per cycle, MSB first.
// Divide-by-zero skips the iteration and returns quotient 8'hFF with a flag.
module div8u4_restoring_seq (
   input  logic       clk,
   input  logic       rst,
   input  logic       in_valid,
   output logic       in_ready,
   input  logic [7:0] dividend,
   input  logic [3:0] divisor,
   output logic       out_valid,
   input  logic       out_ready,
   output logic [7:0] quotient,
   output logic [3:0] remainder,
   output logic       div_by_zero
);

   typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

   state_e     state_q, state_d;
   logic [7:0] work_q;     // dividend bits shift out the top, quotient bits shift in the bottom
   logic [3:0] dvs_q;
   logic [3:0] prem_q;
   logic [2:0] cnt_q;

   logic [4:0] trial;
   logic       take;
   logic [3:0] prem_next;
   logic [7:0] work_next;
   logic       accept;
   logic       busy_step;

   always_comb begin
      trial     = {prem_q, work_q[7]};
      take      = trial >= {1'b0, dvs_q};
      // trial < 2*divisor, so the difference always fits in 4 bits
      prem_next = take ? 4'(trial - {1'b0, dvs_q}) : trial[3:0];
      work_next = {work_q[6:0], take};
      accept    = (state_q == StIdle) && in_valid;
      busy_step = (state_q == StBusy);
   end

   always_comb begin
      state_d   = state_q;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      case (state_q)
         StIdle: begin
            in_ready = 1'b1;
            if (in_valid) state_d = (divisor == 4'd0) ? StDone : StBusy;
         end
         StBusy: begin
            if (cnt_q == 3'd7) state_d = StDone;
         end
         StDone: begin
            out_valid = 1'b1;
            if (out_ready) state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= StIdle;
      else     state_q <= state_d;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         work_q      <= 8'h00;
         dvs_q       <= 4'h0;
         prem_q      <= 4'h0;
         cnt_q       <= 3'd0;
         quotient    <= 8'h00;
         remainder   <= 4'h0;
         div_by_zero <= 1'b0;
      end else if (accept) begin
         work_q <= dividend;
         dvs_q  <= divisor;
         prem_q <= 4'h0;
         cnt_q  <= 3'd0;
         if (divisor == 4'd0) begin
            quotient    <= 8'hFF;
            remainder   <= 4'h0;
            div_by_zero <= 1'b1;
         end
      end else if (busy_step) begin
         work_q <= work_next;
         prem_q <= prem_next;
         cnt_q  <= cnt_q + 3'd1;
         if (cnt_q == 3'd7) begin
            quotient    <= work_next;
            remainder   <= prem_next;
            div_by_zero <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_div8u4_restoring_seq.sv
// Scoreboard bench for div8u4_restoring_seq: driver pushes expected results at accept,
// a negedge monitor pops and compares on every output handshake.
module tb_div8u4_restoring_seq;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       in_valid = 1'b0;
   logic       in_ready;
   logic [7:0] dividend = 8'h00;
   logic [3:0] divisor = 4'h0;
   logic       out_valid;
   logic       out_ready = 1'b1;
   logic [7:0] quotient;
   logic [3:0] remainder;
   logic       div_by_zero;

   int         n_checks = 0;
   int         n_fail = 0;
   logic [12:0] sb[$];
   logic [12:0] last_res = 13'h0;
   bit          rdy_rand = 1'b0;

   div8u4_restoring_seq dut (
      .clk         (clk),
      .rst         (rst),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .dividend    (dividend),
      .divisor     (divisor),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .quotient    (quotient),
      .remainder   (remainder),
      .div_by_zero (div_by_zero)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic fail_event(input string name);
      n_checks++;
      n_fail++;
      $display("FAIL %s (t=%0t)", name, $time);
   endtask

   // Monitor: a handshake seen at negedge completes on the following posedge.
   always @(negedge clk) begin
      if (!rst && out_valid && out_ready) begin
         if (sb.size() == 0) fail_event("unexpected_result");
         else check("result", 32'({quotient, remainder, div_by_zero}), 32'(sb.pop_front()));
      end
   end

   always @(posedge clk) begin
      #1;
      if (rdy_rand) out_ready = 1'($urandom_range(0, 1));
   end

   task automatic run_op(input logic [7:0] a, input logic [3:0] b, input logic [7:0] eq,
                         input logic [3:0] er, input logic ez, input bit wait_done);
      int k;
      int j;
      for (j = 0; j < 50; j++) begin
         if (in_ready) break;
         @(negedge clk);
      end
      if (j == 50) fail_event("in_ready_timeout");
      dividend = a;
      divisor  = b;
      in_valid = 1'b1;
      @(posedge clk);
      sb.push_back({eq, er, ez});
      #1;
      in_valid = 1'b0;
      dividend = 8'($urandom);
      divisor  = 4'($urandom);
      for (k = 0; k < 20; k++) begin
         @(negedge clk);
         if (out_valid) break;
         check("in_ready_busy", 32'(in_ready), 32'd0);
         check("hold_prev", 32'({quotient, remainder, div_by_zero}), 32'(last_res));
      end
      if (k == 20) fail_event("out_valid_timeout");
      else check("latency", 32'(k), ez ? 32'd0 : 32'd8);
      last_res = {eq, er, ez};
      if (wait_done) begin
         for (j = 0; j < 200; j++) begin
            @(negedge clk);
            if (!out_valid) break;
            check("in_ready_done", 32'(in_ready), 32'd0);
         end
         if (j == 200) fail_event("handshake_timeout");
      end
   endtask

   initial begin
      #(1500000);
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      #1;
      check("rst_in_ready", 32'(in_ready), 32'd1);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_outputs", 32'({quotient, remainder, div_by_zero}), 32'd0);
      @(negedge clk);
      rst = 1'b0;

      run_op(8'd100, 4'd7, 8'd14, 4'd2, 1'b0, 1'b1);
      run_op(8'd255, 4'd1, 8'd255, 4'd0, 1'b0, 1'b1);
      run_op(8'd255, 4'd15, 8'd17, 4'd0, 1'b0, 1'b1);
      run_op(8'd0, 4'd9, 8'd0, 4'd0, 1'b0, 1'b1);
      run_op(8'd200, 4'd0, 8'hFF, 4'd0, 1'b1, 1'b1);
      run_op(8'd9, 4'd4, 8'd2, 4'd1, 1'b0, 1'b1);

      // Backpressure: result held, new offers ignored
      out_ready = 1'b0;
      run_op(8'd77, 4'd5, 8'd15, 4'd2, 1'b0, 1'b0);
      repeat (20) begin
         @(posedge clk);
         #1;
         in_valid = 1'b1;
         dividend = 8'($urandom);
         divisor  = 4'($urandom);
         @(negedge clk);
         check("bp_out_valid", 32'(out_valid), 32'd1);
         check("bp_in_ready", 32'(in_ready), 32'd0);
         check("bp_hold", 32'({quotient, remainder, div_by_zero}), 32'({8'd15, 4'd2, 1'b0}));
      end
      @(posedge clk);
      #1;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      @(negedge clk);
      check("bp_release_idle", 32'({in_ready, out_valid}), 32'b10);
      check("bp_retain", 32'({quotient, remainder, div_by_zero}), 32'({8'd15, 4'd2, 1'b0}));

      // Reset in the 4th BUSY cycle discards the in-flight 123/11
      dividend = 8'd123;
      divisor  = 4'd11;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b1;
      #1;
      check("mid_rst_outputs", 32'({quotient, remainder, div_by_zero}), 32'd0);
      check("mid_rst_ready", 32'({in_ready, out_valid}), 32'b10);
      @(negedge clk);
      rst = 1'b0;
      last_res = 13'h0;
      repeat (12) begin
         @(negedge clk);
         check("no_valid_after_rst", 32'(out_valid), 32'd0);
      end
      run_op(8'd123, 4'd11, 8'd11, 4'd2, 1'b0, 1'b1);

      // Exhaustive sweep with random backpressure
      rdy_rand = 1'b1;
      for (int a = 0; a < 256; a++) begin
         for (int b = 0; b < 16; b++) begin
            if (b == 0) run_op(8'(a), 4'd0, 8'hFF, 4'd0, 1'b1, 1'b1);
            else        run_op(8'(a), 4'(b), 8'(a / b), 4'(a % b), 1'b0, 1'b1);
         end
      end
      rdy_rand  = 1'b0;
      out_ready = 1'b1;
      repeat (3) @(negedge clk);
      check("sb_empty", 32'(sb.size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
